// File: rtl/blinds_pkg.sv
// blinds_pkg: shared state encoding and direction helpers for the blinds position controller
package blinds_pkg;
  typedef enum logic [1:0] {IDLE, UP, DOWN, DEAD} state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  function automatic state_t seek(input logic gt, input logic lt);
    return gt ? UP : lt ? DOWN : IDLE;
  endfunction
endpackage

// File: rtl/blinds_pos_ctrl_if.sv
// blinds_pos_ctrl_if: selector request side and motor/status side of the blinds controller
interface blinds_pos_ctrl_if #(parameter int SEL_W = 2, parameter int POS_W = 8);
  logic [SEL_W-1:0] sel;
  logic [POS_W*(2**SEL_W)-1:0] presets;
  logic req;
  logic halt;
  logic motor_up;
  logic motor_down;
  logic [POS_W-1:0] pos;
  logic busy;
  logic done;
  modport master(output sel, presets, req, halt, input motor_up, motor_down, pos, busy, done);
  modport slave(input sel, presets, req, halt, output motor_up, motor_down, pos, busy, done);
endinterface

// File: rtl/blinds_step_timer.sv
// blinds_step_timer: prescaler producing one tick every DIV enabled cycles
module blinds_step_timer #(parameter int DIV = 16) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/blinds_pos_ctrl.sv
// blinds_pos_ctrl: steps an up/down blind motor toward a selected preset position
module blinds_pos_ctrl
  import blinds_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int POS_W = 8,
  parameter int STEP_DIV = 16,
  parameter int DEAD_CYC = 8
) (
  input logic clk,
  input logic rst_n,
  blinds_pos_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEAD_CYC + 1);
  state_t state, nxt, sk;
  logic [POS_W-1:0] pos, pos_s, tgt, tgt_d, t_new;
  logic [DW-1:0] dcnt;
  logic moving, tick, step, dexp, dir, done_d, up_d, dn_d, busy_d;
  logic up_q, dn_q, busy_q, done_q;
  assign moving = state == UP || state == DOWN;
  assign dir = state == UP ? DIR_UP : DIR_DOWN;
  assign step = tick && !bus.halt;
  assign pos_s = !step ? pos : dir == DIR_UP ? pos + 1'b1 : pos - 1'b1;
  assign t_new = bus.req ? bus.presets[bus.sel*POS_W +: POS_W] : tgt;
  assign dexp = state == DEAD && dcnt == DW'(DEAD_CYC - 1);
  blinds_step_timer #(.DIV(STEP_DIV)) u_timer (
    .clk(clk), .rst_n(rst_n), .clr(!moving), .en(moving), .tick(tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pos <= '0;
      tgt <= '0;
      dcnt <= '0;
    end else begin
      state <= nxt;
      pos <= pos_s;
      tgt <= tgt_d;
      dcnt <= state == DEAD ? dcnt + 1'b1 : '0;
    end
  // Direction is always judged against the post-step position.
  always_comb begin
    sk = seek(t_new > pos_s, t_new < pos_s);
    nxt = state;
    tgt_d = t_new;
    done_d = 1'b0;
    if (bus.halt) begin
      nxt = IDLE;
      tgt_d = pos;
    end else if (state == IDLE) begin
      nxt = bus.req ? sk : IDLE;
      done_d = bus.req && sk == IDLE;
    end else if (moving) begin
      nxt = (sk == IDLE || sk == state) ? sk : DEAD;
      done_d = sk == IDLE;
    end else if (dexp) begin
      nxt = sk;
      done_d = sk == IDLE;
    end
  end
  always_comb begin
    up_d = nxt == UP;
    dn_d = nxt == DOWN;
    busy_d = nxt != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      up_q <= 1'b0;
      dn_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      up_q <= up_d;
      dn_q <= dn_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign bus.motor_up = up_q;
  assign bus.motor_down = dn_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pos = pos;
endmodule

// File: tb/tb_blinds_pos_ctrl.sv
// tb_blinds_pos_ctrl: directed scenario tests for the blinds position controller
module tb_blinds_pos_ctrl;
  logic clk, rst_n;
  int errors = 0;
  int checks = 0;
  blinds_pos_ctrl_if #(.SEL_W(2), .POS_W(4)) bus ();
  blinds_pos_ctrl #(.SEL_W(2), .POS_W(4), .STEP_DIV(4), .DEAD_CYC(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic start_req(input int s);
    bus.sel = 2'(s);
    bus.req = 1'b1;
    cyc();
    bus.req = 1'b0;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask
  task automatic test_reset;
    logic [7:0] g;
    rst_n = 1'b0;
    cyc();
    cyc();
    g = {bus.motor_up, bus.motor_down, bus.busy, bus.done, bus.pos};
    checks++;
    if (g !== 8'h00) begin errors++; $display("FAIL reset got=%b exp=%b", g, 8'h00); end
    rst_n = 1'b1;
    cyc();
  endtask
  task automatic test_step_up;
    logic [7:0] g, e;
    start_req(2);
    for (int c = 1; c <= 42; c++) begin
      g = {bus.motor_up, bus.motor_down, bus.busy, bus.done, bus.pos};
      e = {c < 41, 1'b0, c < 41, c == 41, 4'(c >= 41 ? 10 : (c - 1) / 4)};
      checks++;
      if (g !== e) begin errors++; $display("FAIL step_up c=%0d got=%b exp=%b", c, g, e); end
      if (c < 42) cyc();
    end
  endtask
  task automatic test_same_target;
    logic [7:0] g, e;
    start_req(2);
    for (int c = 1; c <= 2; c++) begin
      g = {bus.motor_up, bus.motor_down, bus.busy, bus.done, bus.pos};
      e = {3'b000, c == 1, 4'd10};
      checks++;
      if (g !== e) begin errors++; $display("FAIL same_target c=%0d got=%b exp=%b", c, g, e); end
      if (c < 2) cyc();
    end
  endtask
  task automatic test_reverse;
    logic [7:0] g, e;
    int ep;
    do_reset();
    start_req(3);
    for (int c = 1; c <= 53; c++) begin
      bus.req = 1'b0;
      ep = c <= 25 ? (c - 1) / 4 : c <= 32 ? 6 : 6 - (c - 29) / 4;
      g = {bus.motor_up, bus.motor_down, bus.busy, bus.done, bus.pos};
      e = {c <= 25, c >= 29 && c < 53, c < 53, c == 53, 4'(ep)};
      checks++;
      if (g !== e) begin errors++; $display("FAIL reverse c=%0d got=%b exp=%b", c, g, e); end
      if (c == 25) begin bus.sel = 2'd0; bus.req = 1'b1; end
      if (c < 53) cyc();
    end
    bus.req = 1'b0;
  endtask
  task automatic test_retarget_same_dir;
    logic [7:0] g, e;
    start_req(2);
    for (int c = 1; c <= 61; c++) begin
      bus.req = 1'b0;
      g = {bus.motor_up, bus.motor_down, bus.busy, bus.done, bus.pos};
      e = {c < 61, 1'b0, c < 61, c == 61, 4'((c - 1) / 4)};
      checks++;
      if (g !== e) begin errors++; $display("FAIL retarget c=%0d got=%b exp=%b", c, g, e); end
      if (c == 17) begin bus.sel = 2'd3; bus.req = 1'b1; end
      if (c < 61) cyc();
    end
    bus.req = 1'b0;
  endtask
  task automatic test_halt;
    logic [7:0] g, e;
    logic ed;
    int ep;
    start_req(1);
    for (int c = 1; c <= 45; c++) begin
      bus.req = 1'b0;
      bus.halt = c == 33 || c == 34;
      ep = c <= 33 ? 15 - (c - 1) / 4 : c < 37 ? 7 : 7 - (c - 37) / 4;
      ed = c <= 33 || (c >= 37 && c < 45);
      g = {bus.motor_up, bus.motor_down, bus.busy, bus.done, bus.pos};
      e = {1'b0, ed, ed, c == 45, 4'(ep)};
      checks++;
      if (g !== e) begin errors++; $display("FAIL halt c=%0d got=%b exp=%b", c, g, e); end
      if (c == 33) begin bus.sel = 2'd3; bus.req = 1'b1; end
      if (c == 36) begin bus.sel = 2'd1; bus.req = 1'b1; end
      if (c < 45) cyc();
    end
    bus.req = 1'b0;
    bus.halt = 1'b0;
  endtask
  task automatic test_async_reset;
    logic [7:0] g, e;
    start_req(3);
    repeat (5) cyc();
    g = {bus.motor_up, bus.motor_down, bus.busy, bus.done, bus.pos};
    e = {1'b1, 1'b0, 1'b1, 1'b0, 4'd6};
    checks++;
    if (g !== e) begin errors++; $display("FAIL pre_reset got=%b exp=%b", g, e); end
    #2 rst_n = 1'b0;
    #1;
    g = {bus.motor_up, bus.motor_down, bus.busy, bus.done, bus.pos};
    checks++;
    if (g !== 8'h00) begin errors++; $display("FAIL async_reset got=%b exp=%b", g, 8'h00); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    cyc();
    g = {bus.motor_up, bus.motor_down, bus.busy, bus.done, bus.pos};
    checks++;
    if (g !== 8'h00) begin errors++; $display("FAIL post_reset got=%b exp=%b", g, 8'h00); end
  endtask
  initial begin
    rst_n = 1'b0;
    bus.req = 1'b0;
    bus.halt = 1'b0;
    bus.sel = 2'd0;
    bus.presets = {4'd15, 4'd10, 4'd5, 4'd0};
    test_reset();
    test_step_up();
    test_same_target();
    test_reverse();
    test_retarget_same_dir();
    test_halt();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/blinds_pos_ctrl.md
Name: blinds_pos_ctrl

Overview:
Sequential successor to the combinational blinds selector. A selector code picks one of 2^SEL_W preset positions. The block then drives an up/down motor, one step per prescaled tick, until the tracked blind position equals the target. It sits between the user-facing selector logic and the motor driver pins. It handles retargeting mid-move, direction-reversal dead time and an emergency halt.

Parameters:
SEL_W, 2, selector width; number of presets = 2^SEL_W
POS_W, 8, position/counter width; position range 0..2^POS_W-1 (0 = closed)
STEP_DIV, 16, clock cycles per motor step (>=2)
DEAD_CYC, 8, motor-off cycles enforced before a direction reversal (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
sel  in  SEL_W  preset select (0 = closed ... 2^SEL_W-1 = fully open)
presets  in  POS_W*2^SEL_W  packed preset table; slice k = target for sel==k; held quasi-static
req  in  1  one-cycle strobe; latch presets[sel] as new target
halt  in  1  level; stop motion immediately while high
motor_up  out  1  drive blind towards open
motor_down  out  1  drive blind towards closed
pos  out  POS_W  current tracked position
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when target reached

Behaviour:
- Reset (async assert, sync release): state=IDLE, pos=0, target=0, prescaler=0, dead counter=0, all outputs 0.
- All outputs are registered. motor_up and motor_down are never high together.
- States:
  - IDLE: both motors off.
  - UP: motor_up=1.
  - DOWN: motor_down=1.
  - DEAD: both motors off, counting DEAD_CYC cycles.
- req in IDLE (cycle n), target T = presets[sel] sampled at n:
  - T>pos: UP from n+1.
  - T<pos: DOWN from n+1.
  - T==pos: stay IDLE, done=1 at n+1.
- Stepping: the prescaler resets to 0 on entry to UP/DOWN. The step fires when the prescaler hits STEP_DIV-1, then wraps. On the step cycle pos increments (UP) or decrements (DOWN). The first step lands STEP_DIV cycles after the motor asserts.
- Arrival: if the step makes pos==target, the next state is IDLE. The motor drops and done pulses in the same cycle that pos shows the final value.
- req while moving:
  - Same direction, or T equal to the current position's side: update target, prescaler untouched, motion continues.
  - T==pos: go IDLE next cycle with done.
  - Opposite direction: go to DEAD (motors off, prescaler cleared), wait DEAD_CYC cycles, then enter the new direction.
- req while in DEAD: update target. At DEAD expiry, direction is chosen from the latest target; if target==pos, go IDLE with done.
- halt=1 has priority over req in every state:
  - Next state IDLE, motors off, pos retained, target:=pos, no done.
  - req is ignored while halt is high.
- req and a step on the same cycle: the step is applied first. Direction is then evaluated against the post-step pos.
- pos never wraps. Targets are in range by construction, and motion only occurs toward the target.
- Reset mid-motion: motors drop asynchronously and pos returns to 0. Re-homing is system-level, not this block's job.

Decomposition:
- Package blinds_pkg: state enum {IDLE, UP, DOWN, DEAD}, and direction encoding constants.
- Sub-module blinds_step_timer (prescaler: clear, enable, tick out) is natural and reusable; instantiate once.
- The preset mux stays inline.

Test Plan:
Common setup: SEL_W=2, POS_W=4, STEP_DIV=4, DEAD_CYC=3, presets={15,10,5,0} for sel 3..0.
1. Reset, then req with sel=2 -> motor_up from the next cycle; pos steps 1..10 every 4 cycles; done pulses once at pos=10, same cycle motor_up drops; busy low after.
2. At pos=10 idle, req sel=2 -> no motor activity; done=1 the following cycle.
3. Moving up from 0 toward 15, req sel=0 at pos=6 -> motors off for 3 cycles (DEAD); then motor_down; pos reaches 0 with done.
4. Moving up toward 10, req sel=3 at pos=4 -> no DEAD, no gap in motor_up; stops at 15.
5. Moving down, assert halt at pos=7 together with req sel=3 -> next cycle IDLE, pos=7 held, no done, req ignored; after release, req sel=1 -> DOWN to 5.
6. Assert rst_n low mid-move -> motor outputs 0 immediately (asynchronously), pos=0, busy=0.
